// File: rtl/ldpc_pkg.sv
// Shared widths, frame geometry and state encodings for the LDPC front end.
// Also holds the helper that turns a hard bit and a magnitude into a signed LLR.
package ldpc_pkg;

  localparam int N      = 204;
  localparam int LOG2N  = 8;
  localparam int INT_W  = 8;
  localparam int FRAC_W = 8;
  localparam int LLR_W  = INT_W + FRAC_W;
  localparam int MAG_W  = LLR_W - 1;
  localparam int WORD_W = LLR_W + 1;

  localparam logic [LOG2N-1:0] LAST_PTR = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] N_ADDR   = LOG2N'(N);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_IN_USE  = 2'd3
  } bank_state_e;

  typedef enum logic [1:0] {
    W_FILL  = 2'd0,
    W_FLUSH = 2'd1,
    W_WAIT  = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_BUSY = 1'b1
  } rd_state_e;

  // Positive LLR means bit 1, so a zero bit stores the negated magnitude.
  function automatic logic [LLR_W-1:0] form_llr(input logic hard_bit,
                                                 input logic [MAG_W-1:0] mag);
    logic [LLR_W-1:0] ext;
    ext = {1'b0, mag};
    return hard_bit ? ext : (~ext + LLR_W'(1'b1));
  endfunction

endpackage

// File: rtl/llr_bank_ram.sv
// Two-bank simple dual-port store of {hard bit, LLR} words, indexed by {bank, entry}.
// Registered read port; a disabled read returns zero.
module llr_bank_ram
  import ldpc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [LOG2N:0]    wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              re,
  input  logic [LOG2N:0]    rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [2**(LOG2N+1)];
  logic [WORD_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_q <= {WORD_W{1'b0}};
    end else if (re) begin
      rd_data_q <= mem[rd_addr];
    end else begin
      rd_data_q <= {WORD_W{1'b0}};
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/llr_frame_loader.sv
// Frame loader: packs serial hard bits/magnitudes into signed LLR frames in a
// ping-pong buffer and hands completed banks to the decoder with start/done.
module llr_frame_loader
  import ldpc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic [MAG_W-1:0] in_mag,
  input  logic             in_last,
  output logic             dec_start,
  input  logic             dec_done,
  input  logic [LOG2N-1:0] rd_addr,
  output logic [LLR_W-1:0] rd_llr,
  output logic             rd_bit,
  output logic             frame_err,
  output logic [15:0]      frames_in
);

  bank_state_e       bank_state_q [2];
  bank_state_e       bank_state_d [2];
  wr_state_e         wr_state_q, wr_state_d;
  rd_state_e         rd_state_q, rd_state_d;
  logic [LOG2N-1:0]  wr_ptr_q, wr_ptr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic              in_ready_q, in_ready_d;
  logic              dec_start_q, dec_start_d;
  logic              frame_err_q, frame_err_d;
  logic [15:0]       frames_in_q, frames_in_d;
  logic              accept_s, release_s, complete_s, we_s;
  logic [WORD_W-1:0] rd_word_s;

  always_comb begin
    bank_state_d = bank_state_q;
    wr_state_d   = wr_state_q;
    rd_state_d   = rd_state_q;
    wr_ptr_d     = wr_ptr_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    dec_start_d  = 1'b0;
    frame_err_d  = 1'b0;
    frames_in_d  = frames_in_q;
    we_s         = 1'b0;
    complete_s   = 1'b0;
    accept_s     = in_valid && in_ready_q;
    release_s    = (rd_state_q == R_BUSY) && dec_done;

    case (wr_state_q)
      W_FILL: begin
        if (accept_s && in_last && (wr_ptr_q == LAST_PTR)) begin
          we_s                    = 1'b1;
          complete_s              = 1'b1;
          bank_state_d[wr_bank_q] = BANK_FULL;
          frames_in_d             = frames_in_q + 16'd1;
          wr_ptr_d                = {LOG2N{1'b0}};
          wr_bank_d               = ~wr_bank_q;
          // A release of the other bank in this same cycle counts as already empty.
          if ((bank_state_q[~wr_bank_q] != BANK_EMPTY) &&
              !(release_s && (rd_bank_q == ~wr_bank_q))) begin
            wr_state_d = W_WAIT;
          end else begin
            wr_state_d = W_FILL;
          end
        end else if (accept_s && in_last) begin
          frame_err_d             = 1'b1;
          bank_state_d[wr_bank_q] = BANK_EMPTY;
          wr_ptr_d                = {LOG2N{1'b0}};
        end else if (accept_s && (wr_ptr_q == LAST_PTR)) begin
          frame_err_d             = 1'b1;
          bank_state_d[wr_bank_q] = BANK_EMPTY;
          wr_ptr_d                = {LOG2N{1'b0}};
          wr_state_d              = W_FLUSH;
        end else if (accept_s) begin
          we_s                    = 1'b1;
          bank_state_d[wr_bank_q] = BANK_FILLING;
          wr_ptr_d                = wr_ptr_q + LOG2N'(1'b1);
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end
      W_FLUSH: begin
        if (accept_s && in_last) begin
          wr_state_d = W_FILL;
        end else begin
          wr_state_d = W_FLUSH;
        end
      end
      W_WAIT: begin
        if ((bank_state_q[wr_bank_q] == BANK_EMPTY) ||
            (release_s && (rd_bank_q == wr_bank_q))) begin
          wr_state_d = W_FILL;
        end else begin
          wr_state_d = W_WAIT;
        end
      end
      default: begin
        wr_state_d = W_FILL;
      end
    endcase

    // A bank completed this cycle can be started without waiting for FULL to settle.
    case (rd_state_q)
      R_IDLE: begin
        if ((bank_state_q[rd_bank_q] == BANK_FULL) ||
            (complete_s && (wr_bank_q == rd_bank_q))) begin
          bank_state_d[rd_bank_q] = BANK_IN_USE;
          dec_start_d             = 1'b1;
          rd_state_d              = R_BUSY;
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_BUSY: begin
        if (dec_done) begin
          bank_state_d[rd_bank_q] = BANK_EMPTY;
          rd_bank_d               = ~rd_bank_q;
          rd_state_d              = R_IDLE;
        end else begin
          rd_state_d = R_BUSY;
        end
      end
      default: begin
        rd_state_d = R_IDLE;
      end
    endcase

    in_ready_d = (wr_state_d != W_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_state_q[0] <= BANK_EMPTY;
      bank_state_q[1] <= BANK_EMPTY;
      wr_state_q      <= W_FILL;
      rd_state_q      <= R_IDLE;
      wr_ptr_q        <= {LOG2N{1'b0}};
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
      in_ready_q      <= 1'b0;
      dec_start_q     <= 1'b0;
      frame_err_q     <= 1'b0;
      frames_in_q     <= 16'd0;
    end else begin
      bank_state_q    <= bank_state_d;
      wr_state_q      <= wr_state_d;
      rd_state_q      <= rd_state_d;
      wr_ptr_q        <= wr_ptr_d;
      wr_bank_q       <= wr_bank_d;
      rd_bank_q       <= rd_bank_d;
      in_ready_q      <= in_ready_d;
      dec_start_q     <= dec_start_d;
      frame_err_q     <= frame_err_d;
      frames_in_q     <= frames_in_d;
    end
  end

  llr_bank_ram u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (we_s),
    .wr_addr ({wr_bank_q, wr_ptr_q}),
    .wr_data ({in_bit, form_llr(in_bit, in_mag)}),
    .re      (rd_addr < N_ADDR),
    .rd_addr ({rd_bank_q, rd_addr}),
    .rd_data (rd_word_s)
  );

  assign in_ready  = in_ready_q;
  assign dec_start = dec_start_q;
  assign frame_err = frame_err_q;
  assign frames_in = frames_in_q;
  assign rd_llr    = rd_word_s[LLR_W-1:0];
  assign rd_bit    = rd_word_s[LLR_W];

endmodule
